// File: rtl/axis_rr_merge_16x2.sv
// Packet-granular round-robin merge of two AXI-Stream lanes into one registered output.
// A lane keeps the grant from the arbitration cycle until its tlast beat is accepted.
`timescale 1ns/1ps
module axis_rr_merge_16x2 #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic              en,
  input  logic [DATA_W-1:0] s_axis_a_tdata,
  input  logic              s_axis_a_tvalid,
  output logic              s_axis_a_tready,
  input  logic              s_axis_a_tlast,
  input  logic [DATA_W-1:0] s_axis_b_tdata,
  input  logic              s_axis_b_tvalid,
  output logic              s_axis_b_tready,
  input  logic              s_axis_b_tlast,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast,
  output logic              m_axis_tid,
  output logic              busy,
  output logic [CNT_W-1:0]  pkt_cnt_a,
  output logic [CNT_W-1:0]  pkt_cnt_b
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOCK_A = 2'd1,
    LOCK_B = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;
  logic   last_grant;      // 0 = A, 1 = B
  logic   last_grant_nxt;
  logic   load;
  logic   acc_a;
  logic   acc_b;

  // Arbitration, per-lane ready and packet-end detection
  always_comb begin
    state_nxt       = state;
    last_grant_nxt  = last_grant;
    load            = !m_axis_tvalid || m_axis_tready;
    s_axis_a_tready = 1'b0;
    s_axis_b_tready = 1'b0;
    acc_a           = 1'b0;
    acc_b           = 1'b0;
    case (state)
      IDLE: begin
        if (en) begin
          if (s_axis_a_tvalid && (!s_axis_b_tvalid || last_grant)) begin
            state_nxt      = LOCK_A;
            last_grant_nxt = 1'b0;
          end else if (s_axis_b_tvalid) begin
            state_nxt      = LOCK_B;
            last_grant_nxt = 1'b1;
          end
        end
      end
      LOCK_A: begin
        s_axis_a_tready = load;
        acc_a           = s_axis_a_tvalid && load;
        if (acc_a && s_axis_a_tlast) state_nxt = IDLE;
      end
      LOCK_B: begin
        s_axis_b_tready = load;
        acc_b           = s_axis_b_tvalid && load;
        if (acc_b && s_axis_b_tlast) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
    end
  end

  // Single output register; holds while the sink stalls
  always_ff @(posedge aclk) begin
    if (areset) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
      m_axis_tid    <= 1'b0;
    end else if (load) begin
      if (acc_a) begin
        m_axis_tvalid <= 1'b1;
        m_axis_tdata  <= s_axis_a_tdata;
        m_axis_tlast  <= s_axis_a_tlast;
        m_axis_tid    <= 1'b0;
      end else if (acc_b) begin
        m_axis_tvalid <= 1'b1;
        m_axis_tdata  <= s_axis_b_tdata;
        m_axis_tlast  <= s_axis_b_tlast;
        m_axis_tid    <= 1'b1;
      end else begin
        m_axis_tvalid <= 1'b0;
      end
    end
  end

  // Wrap-around packet counters
  always_ff @(posedge aclk) begin
    if (areset) begin
      pkt_cnt_a <= '0;
      pkt_cnt_b <= '0;
    end else begin
      if (acc_a && s_axis_a_tlast) pkt_cnt_a <= pkt_cnt_a + CNT_W'(1);
      if (acc_b && s_axis_b_tlast) pkt_cnt_b <= pkt_cnt_b + CNT_W'(1);
    end
  end

  assign busy = (state != IDLE) || m_axis_tvalid;

endmodule
